dram_dump_ctrl: RTL and testbench
=================================

Name: dram_dump_ctrl

Overview:
- Sequences the data DRAM after the CPU halts, reading every word out to a debug consumer (display or UART) over a valid/ready handshake.
- Drives the MEM stage's `if_end` select and external `address` so the DRAM is indexed by this block instead of the ALU result.
- Captures the asynchronous DRAM read data (`ReadDataM`) and presents it one word at a time, with its address.

Parameters:
- ADDR_W, 7, DRAM word-address width.
- DATA_W, 32, DRAM word width.
- DEPTH, 128, number of words dumped per pass (1..2^ADDR_W).
- START_ADDR, 0, first word address dumped.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  level; CPU has reached end of program and issues no further stores.
- restart  in  1  one-cycle pulse; rewind the dump to START_ADDR.
- rdata  in  DATA_W  DRAM read data (`ReadDataM`), combinational from `address`.
- if_end  out  1  MEM address-select; 1 means the DRAM uses `address`.
- address  out  ADDR_W  DRAM word address during a dump.
- mem_we_mask  out  1  equals ~if_end; integration ANDs it into MemWriteM.
- out_valid  out  1  out_data/out_addr hold a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  captured word.
- out_addr  out  ADDR_W  address of the captured word.
- busy  out  1  dump in progress (CAPTURE or PRESENT).
- done  out  1  all DEPTH words accepted.

Behaviour:
- Reset (async, any state) sets:
  - state=IDLE, if_end=0, address=START_ADDR, word count cnt=0.
  - out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
  - Reset mid-dump drops out_valid immediately; no partial word is presented afterwards.
- All outputs are registered, except mem_we_mask and busy, which are decoded from registered state.
- IDLE: if_end=0. When halt=1, go to CAPTURE; on that transition set if_end=1, address=START_ADDR, cnt=0.
- CAPTURE (one cycle): the DRAM is presenting rdata for `address` this cycle. At the next edge:
  - out_data<=rdata, out_addr<=address, out_valid<=1.
  - go to PRESENT.
- PRESENT: out_valid stays 1; out_data and out_addr are stable until accepted.
  - On out_valid&&out_ready, at the edge: out_valid<=0.
  - If cnt==DEPTH-1: go to DONE.
  - Else: cnt<=cnt+1, address<=address+1 (mod 2^ADDR_W), go to CAPTURE.
- DONE: done=1, if_end stays 1 (memory frozen), out_valid=0. Hold until halt=0 or restart.
- Latency:
  - halt to first out_valid: 2 cycles.
  - Peak throughput: 1 word per 2 cycles with out_ready tied high.
  - A full pass with ready high: 2*DEPTH cycles to done.
- Wrap-around: termination uses cnt, never an address compare. START_ADDR+DEPTH > 2^ADDR_W wraps the address to 0 and still ends after exactly DEPTH words.
- halt falls in CAPTURE, PRESENT or DONE: abort at the next edge.
  - Go to IDLE; if_end<=0, out_valid<=0, done<=0.
  - A word pending in PRESENT is discarded even if out_ready is high that cycle; abort wins.
- restart while halt=1, in any non-IDLE state:
  - Go to CAPTURE with address=START_ADDR, cnt=0, out_valid<=0, done<=0.
  - Restart wins over a same-cycle handshake.
- restart in IDLE is ignored.
- halt=0 and restart in the same cycle: abort wins.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, CAPTURE, PRESENT, DONE; 2-bit);
  - the default ADDR_W and DATA_W constants, shared with the MEM stage and DRAM instance.
- No sub-module is needed; a single FSM plus counter and output registers fits comfortably.
- A top level wires address/if_end into MEM and ANDs mem_we_mask into MemWriteM.

Test Plan:
- Reset, DRAM preloaded with mem[i]=i*4+0x100, halt rises, out_ready=1 -> first out_valid 2 cycles later with out_addr=0, out_data=0x100; done rises after 256 cycles; words 0..127 appear in order.
- Backpressure: out_ready low for 5 cycles on word 3 -> out_valid, out_addr=3 and out_data=0x10C held stable; address does not advance; word 4 follows after ready.
- Wrap: START_ADDR=120, DEPTH=16 -> out_addr sequence 120..127, 0..7; done after the 16th accept; no 17th valid.
- Abort: halt drops while presenting word 10 with out_ready=1 -> next cycle out_valid=0, if_end=0, state IDLE; re-raising halt restarts at out_addr=0.
- Restart in DONE, and again mid-dump at word 50 -> out_valid clears; next word has out_addr=START_ADDR; done=0 until the full pass repeats.
- Async reset asserted mid-PRESENT, between clock edges -> out_valid, if_end and busy go to 0 without waiting for clk; mem_we_mask=1.

Source files
------------

// File: rtl/dram_dump_ctrl_pkg.sv
// Shared constants for the post-halt DRAM dump path: default bus widths used by
// MEM/DRAM and the dump FSM state encoding.
package dram_dump_ctrl_pkg;
  localparam int DUMP_ADDR_W = 7;
  localparam int DUMP_DATA_W = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;
endpackage

// File: rtl/dram_dump_ctrl_if.sv
// Word stream from the dump controller to a debug consumer (display/UART).
interface dram_dump_ctrl_if
  import dram_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (output out_valid, out_data, out_addr, input out_ready);
  modport slave  (input out_valid, out_data, out_addr, output out_ready);
endinterface

// File: rtl/dram_dump_ctrl.sv
// Post-halt DRAM dump: steals the MEM-stage address mux, walks DEPTH words from
// START_ADDR and presents each captured word over a valid/ready stream.
module dram_dump_ctrl
  import dram_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DUMP_ADDR_W,
  parameter int DATA_W     = DUMP_DATA_W,
  parameter int DEPTH      = 128,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              restart,
  input  logic [DATA_W-1:0] rdata,
  output logic              if_end,
  output logic [ADDR_W-1:0] address,
  output logic              mem_we_mask,
  output logic              busy,
  output logic              done,
  dram_dump_ctrl_if.master  out_if
);
  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic              if_end_q, if_end_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    if_end_d = if_end_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    oaddr_d  = oaddr_q;
    done_d   = done_q;
    if (state_q == ST_IDLE) begin
      if (halt) begin
        state_d  = ST_CAPTURE;
        if_end_d = 1'b1;
        addr_d   = START_A;
        cnt_d    = '0;
      end
    end else if (!halt) begin
      // abort beats restart and any same-cycle handshake
      state_d  = ST_IDLE;
      if_end_d = 1'b0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end else if (restart) begin
      state_d = ST_CAPTURE;
      addr_d  = START_A;
      cnt_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          data_d  = rdata;
          oaddr_d = addr_q;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_if.out_ready) begin
            valid_d = 1'b0;
            if (cnt_q == LAST_CNT) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              // count terminates the pass; the address is free to wrap
              cnt_d   = cnt_q + ADDR_W'(1);
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_CAPTURE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      if_end_q <= 1'b0;
      addr_q   <= START_A;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      oaddr_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      if_end_q <= if_end_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      oaddr_q  <= oaddr_d;
      done_q   <= done_d;
    end
  end

  assign if_end           = if_end_q;
  assign address          = addr_q;
  assign mem_we_mask      = ~if_end_q;
  assign busy             = (state_q == ST_CAPTURE) || (state_q == ST_PRESENT);
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_addr  = oaddr_q;
endmodule

// File: tb/tb_dram_dump_ctrl.sv
// Bench for dram_dump_ctrl: a full-depth instance (A) and a wrapping 16-word
// instance (B) sharing one preloaded DRAM image.
module tb_dram_dump_ctrl;
  import dram_dump_ctrl_pkg::*;

  localparam int DEPTH_A = 128, START_A = 0;
  localparam int DEPTH_B = 16,  START_B = 120;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] mem [128];
  logic        halt [2], restart [2], rdy [2];
  logic        vld [2], if_end [2], wem [2], busy [2], done [2];
  logic [6:0]  addr [2], oaddr [2];
  logic [31:0] odata [2], rdata [2];

  int n_tests = 0, n_fail = 0;

  dram_dump_ctrl_if #(.ADDR_W(7), .DATA_W(32)) dif_a ();
  dram_dump_ctrl_if #(.ADDR_W(7), .DATA_W(32)) dif_b ();

  assign rdata[0] = mem[addr[0]];
  assign rdata[1] = mem[addr[1]];
  assign dif_a.out_ready = rdy[0];
  assign dif_b.out_ready = rdy[1];
  assign vld[0] = dif_a.out_valid;  assign vld[1] = dif_b.out_valid;
  assign odata[0] = dif_a.out_data; assign odata[1] = dif_b.out_data;
  assign oaddr[0] = dif_a.out_addr; assign oaddr[1] = dif_b.out_addr;

  dram_dump_ctrl #(.ADDR_W(7), .DATA_W(32), .DEPTH(DEPTH_A), .START_ADDR(START_A)) u_a (
    .clk(clk), .rst(rst), .halt(halt[0]), .restart(restart[0]), .rdata(rdata[0]),
    .if_end(if_end[0]), .address(addr[0]), .mem_we_mask(wem[0]), .busy(busy[0]),
    .done(done[0]), .out_if(dif_a));

  dram_dump_ctrl #(.ADDR_W(7), .DATA_W(32), .DEPTH(DEPTH_B), .START_ADDR(START_B)) u_b (
    .clk(clk), .rst(rst), .halt(halt[1]), .restart(restart[1]), .rdata(rdata[1]),
    .if_end(if_end[1]), .address(addr[1]), .mem_we_mask(wem[1]), .busy(busy[1]),
    .done(done[1]), .out_if(dif_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: word k of a pass is at (start+k) mod 128 and holds 0x100 + 4*addr.
  // Each word costs 2 cycles plus one per backpressured cycle, so done appears
  // 2*depth+1+stalls negedges after the cycle halt/restart is applied.
  task automatic run(input int s, input bit use_restart, input int stall_word,
                     input int stall_len, input bit rnd, input int stop_at,
                     output int done_c);
    int depth, start, idx, stalls, rem, first_v;
    logic [6:0] ea;
    depth = (s == 0) ? DEPTH_A : DEPTH_B;
    start = (s == 0) ? START_A : START_B;
    idx = 0; stalls = 0; rem = stall_len; first_v = -1; done_c = -1;
    if (use_restart) restart[s] = 1'b1; else halt[s] = 1'b1;
    rdy[s] = 1'b1;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      restart[s] = 1'b0;
      if (c == 1) begin
        chk("capture_valid", 32'(vld[s]), 0);
        chk("capture_busy", 32'(busy[s]), 1);
        chk("capture_if_end", 32'(if_end[s]), 1);
        chk("capture_done", 32'(done[s]), 0);
        chk("capture_we_mask", 32'(wem[s]), 0);
      end
      if (done[s]) begin done_c = c; break; end
      if (vld[s]) begin
        ea = 7'((start + idx) % 128);
        if (first_v < 0) begin first_v = c; chk("first_valid_latency", c, 2); end
        if (idx == stop_at) return;
        chk("out_addr", 32'(oaddr[s]), 32'(ea));
        chk("out_data", odata[s], 32'h100 + 32'(ea) * 4);
        chk("address_hold", 32'(addr[s]), 32'(ea));
        if (idx == stall_word && rem > 0) begin rdy[s] = 1'b0; rem--; end
        else if (rnd) rdy[s] = 1'($urandom_range(0, 1));
        else rdy[s] = 1'b1;
        if (rdy[s]) idx++; else stalls++;
      end else begin
        rdy[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    chk("words_accepted", idx, depth);
    chk("done_cycle", done_c, 2 * depth + 1 + stalls);
  endtask

  task automatic post_done(input int s);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_no_extra_valid", 32'(vld[s]), 0);
      chk("done_hold", 32'(done[s]), 1);
      chk("done_if_end", 32'(if_end[s]), 1);
      chk("done_busy", 32'(busy[s]), 0);
    end
  endtask

  task automatic go_idle(input int s);
    halt[s] = 1'b0; restart[s] = 1'b0;
    @(negedge clk);
    chk("idle_if_end", 32'(if_end[s]), 0);
    chk("idle_valid", 32'(vld[s]), 0);
    chk("idle_done", 32'(done[s]), 0);
    chk("idle_busy", 32'(busy[s]), 0);
    chk("idle_we_mask", 32'(wem[s]), 1);
  endtask

  typedef struct {
    int sel;
    int stall_word;
    int stall_len;
    int exp_done_c;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int dc;
    for (int i = 0; i < 128; i++) mem[i] = 32'h100 + 32'(i) * 4;
    tbl[0] = '{0, -1, 0, 257};
    tbl[1] = '{0, 3, 5, 262};
    tbl[2] = '{0, 127, 3, 260};
    tbl[3] = '{1, -1, 0, 33};
    tbl[4] = '{1, 2, 4, 37};
    for (int s = 0; s < 2; s++) begin halt[s] = 0; restart[s] = 0; rdy[s] = 0; end

    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", 32'(vld[s]), 0);
      chk("rst_if_end", 32'(if_end[s]), 0);
      chk("rst_busy", 32'(busy[s]), 0);
      chk("rst_done", 32'(done[s]), 0);
      chk("rst_we_mask", 32'(wem[s]), 1);
      chk("rst_out_data", odata[s], 0);
      chk("rst_out_addr", 32'(oaddr[s]), 0);
      chk("rst_address", 32'(addr[s]), (s == 0) ? START_A : START_B);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_halt", 32'(if_end[0]), 0);

    // Full passes, backpressure and wrap-around
    foreach (tbl[i]) begin
      run(tbl[i].sel, 1'b0, tbl[i].stall_word, tbl[i].stall_len, 1'b0, -1, dc);
      chk($sformatf("tbl%0d_done_cycle", i), dc, tbl[i].exp_done_c);
      post_done(tbl[i].sel);
      go_idle(tbl[i].sel);
    end

    // Random consumer backpressure
    for (int r = 0; r < 3; r++) begin run(0, 1'b0, -1, 0, 1'b1, -1, dc); go_idle(0); end
    for (int r = 0; r < 3; r++) begin run(1, 1'b0, -1, 0, 1'b1, -1, dc); go_idle(1); end

    // Abort while presenting word 10 with ready high, then re-halt from scratch
    run(0, 1'b0, -1, 0, 1'b0, 10, dc);
    chk("abort_pre_valid", 32'(vld[0]), 1);
    go_idle(0);
    run(0, 1'b0, -1, 0, 1'b0, -1, dc);
    post_done(0);

    // Restart in DONE repeats the full pass
    run(0, 1'b1, -1, 0, 1'b0, -1, dc);
    chk("restart_done_cycle", dc, 257);
    go_idle(0);

    // Restart mid-dump at word 50 beats the same-cycle handshake
    run(0, 1'b0, -1, 0, 1'b0, 50, dc);
    run(0, 1'b1, -1, 0, 1'b0, -1, dc);
    go_idle(0);

    // halt low and restart together: abort wins
    run(0, 1'b0, -1, 0, 1'b0, 5, dc);
    halt[0] = 1'b0; restart[0] = 1'b1;
    @(negedge clk);
    restart[0] = 1'b0;
    chk("abort_over_restart_if_end", 32'(if_end[0]), 0);
    chk("abort_over_restart_valid", 32'(vld[0]), 0);
    chk("abort_over_restart_busy", 32'(busy[0]), 0);

    // restart in IDLE is ignored
    restart[0] = 1'b1;
    @(negedge clk);
    restart[0] = 1'b0;
    chk("idle_restart_if_end", 32'(if_end[0]), 0);
    chk("idle_restart_busy", 32'(busy[0]), 0);
    @(negedge clk);
    chk("idle_restart_valid", 32'(vld[0]), 0);

    // Async reset between edges while a word is pending
    run(0, 1'b0, -1, 0, 1'b0, 7, dc);
    rdy[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(vld[0]), 0);
    chk("async_rst_if_end", 32'(if_end[0]), 0);
    chk("async_rst_busy", 32'(busy[0]), 0);
    chk("async_rst_we_mask", 32'(wem[0]), 1);
    chk("async_rst_address", 32'(addr[0]), START_A);
    @(negedge clk);
    halt[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(vld[0]), 0);
    chk("post_rst_if_end", 32'(if_end[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
